f_fetch_unit: RTL

- Instruction-fetch (F) stage of the 5-stage MIPS pipeline. It holds the PC, drives instruction-memory addressing, and selects the next PC.
- Next-PC sources: sequential, branch/jump, exception entry, eret.
- Produces the instr / pc / delay / excCode bundle that the IF/ID pipeline register captures each unfrozen cycle.
- Buffers a redirect that arrives while the pipeline is frozen, so no control transfer is lost.

---
 rtl/f_fetch_unit_pkg.sv | 28 ++
 rtl/f_fetch_unit_npc_sel.sv | 61 ++++++
 rtl/f_fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/f_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// f_fetch_unit_pkg
// Shared definitions for the fetch stage, CP0 and the pipeline registers:
// address map constants, exception codes and the fetch-state encoding.
// -----------------------------------------------------------------------------
package f_fetch_unit_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI   = 32'h0000_6FFF;

  localparam logic [4:0] EXC_NONE = 5'd31;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // RUN: fetching normally. PEND: a redirect arrived while frozen and waits
  // in pend_pc for the first unfrozen edge.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

  // A fetch address is illegal if misaligned or outside instruction memory.
  function automatic logic is_fetch_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
  endfunction

endpackage

// File: rtl/f_fetch_unit_npc_sel.sv
// -----------------------------------------------------------------------------
// f_npc_sel
// Purely combinational next-PC priority mux for the fetch stage.
// Ports:
//   i_state          current fetch state (RUN / PEND)
//   i_pc             current PC
//   i_pend_pc        buffered redirect target (valid in PEND)
//   i_pend_is_eret   buffered redirect came from an eret
//   i_exc_req        exception entry request
//   i_eret_req/i_epc eret request and return address
//   i_br_taken/i_br_target  taken branch/jump and its target
//   o_next_pc        PC to load on an unfrozen edge
//   o_pend_pc        value to buffer on a frozen edge with a redirect
//   o_pend_is_eret   whether the buffered value is an eret return address
// -----------------------------------------------------------------------------
module f_npc_sel
  import f_fetch_unit_pkg::*;
(
  input  fetch_state_t i_state,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_pend_pc,
  input  logic         i_pend_is_eret,
  input  logic         i_exc_req,
  input  logic         i_eret_req,
  input  logic [31:0]  i_epc,
  input  logic         i_br_taken,
  input  logic [31:0]  i_br_target,
  output logic [31:0]  o_next_pc,
  output logic [31:0]  o_pend_pc,
  output logic         o_pend_is_eret
);

  logic w_pend_active;
  assign w_pend_active = (i_state == PEND);

  // A live redirect this cycle always beats a buffered one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    o_next_pc = i_pc + 32'd4;
    if (i_exc_req)          o_next_pc = EXC_ENTRY;
    else if (i_eret_req)    o_next_pc = i_epc;
    else if (i_br_taken)    o_next_pc = i_br_target;
    else if (w_pend_active) o_next_pc = i_pend_pc;
  end

  // Capture value while frozen. A branch may replace a buffered branch, but a
  // buffered eret return address is never displaced by a branch.
  always_comb begin
    o_pend_pc      = i_pend_pc;
    o_pend_is_eret = i_pend_is_eret;
    if (i_eret_req) begin
      o_pend_pc      = i_epc;
      o_pend_is_eret = 1'b1;
    end else if (i_br_taken && !(w_pend_active && i_pend_is_eret)) begin
      o_pend_pc      = i_br_target;
      o_pend_is_eret = 1'b0;
    end
  end

endmodule

// File: rtl/f_fetch_unit.sv
// -----------------------------------------------------------------------------
// f_fetch_unit
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives
// instruction memory, selects the next PC and produces the F bundle that the
// IF/ID register captures on the same edge that advances the PC.
// Ports:
//   clk, reset (async, active-high)
//   freeze                 hazard stall, PC holds
//   br_taken, br_target    D-stage taken branch/jump
//   d_is_jump              D holds a branch/jump: F instruction is a delay slot
//   exc_req                exception entry (overrides freeze)
//   eret_req, epc          exception return
//   imem_addr, imem_rdata  instruction memory (combinational read)
//   out_instr, out_pc, out_delay, out_exc_code   F bundle (31 = no exception)
// Configuration:
//   ERET_SQUASH_EN  when defined, the bundle fetched alongside an unfrozen eret
//                   is nullified (eret has no delay slot).
// -----------------------------------------------------------------------------
module f_fetch_unit
  import f_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        d_is_jump,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_delay,
  output logic [4:0]  out_exc_code
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_pc;
  logic         r_pend_is_eret;

  logic [31:0]  w_next_pc;
  logic [31:0]  w_pend_pc;
  logic         w_pend_is_eret;
  logic         w_adel;

  f_npc_sel u_npc_sel (
    .i_state        (r_state),
    .i_pc           (r_pc),
    .i_pend_pc      (r_pend_pc),
    .i_pend_is_eret (r_pend_is_eret),
    .i_exc_req      (exc_req),
    .i_eret_req     (eret_req),
    .i_epc          (epc),
    .i_br_taken     (br_taken),
    .i_br_target    (br_target),
    .o_next_pc      (w_next_pc),
    .o_pend_pc      (w_pend_pc),
    .o_pend_is_eret (w_pend_is_eret)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc           <= PC_RESET;
      r_state        <= RUN;
      r_pend_pc      <= '0;
      r_pend_is_eret <= 1'b0;
    end else if (exc_req) begin
      // Exception entry ignores freeze and drops anything buffered.
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_pc           <= EXC_ENTRY;
      r_state        <= RUN;
      r_pend_pc      <= '0;
      r_pend_is_eret <= 1'b0;
    end else if (freeze) begin
      if (eret_req || br_taken) begin
        r_pend_pc      <= w_pend_pc;
        r_pend_is_eret <= w_pend_is_eret;
        r_state        <= PEND;
      end
    end else begin
      r_pc           <= w_next_pc;
      r_state        <= RUN;
      r_pend_pc      <= '0;
      r_pend_is_eret <= 1'b0;
    end
  end

  assign imem_addr = r_pc;
  assign out_pc    = r_pc;
  assign w_adel    = is_fetch_adel(r_pc);

  always_comb begin
    out_instr    = w_adel ? 32'd0 : imem_rdata;
    out_exc_code = w_adel ? EXC_ADEL : EXC_NONE;
    out_delay    = d_is_jump && !reset;
`ifdef ERET_SQUASH_EN
    if (eret_req && !freeze) begin
      out_instr    = 32'd0;
      out_exc_code = EXC_NONE;
      out_delay    = 1'b0;
    end
`endif
  end

endmodule
